// File: rtl/txshift_fifo.sv
`default_nettype none
// ============================================================================
// txshift_fifo : FIFO-buffered asynchronous serial transmitter
// Rev 1.0
// ============================================================================
module txshift_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_WIDTH = 14
) (
  input  logic                        i_Pclk,
  input  logic                        i_Reset,
  input  logic [BAUD_WIDTH-1:0]       i_Baud,
  input  logic                        i_Enable,
  input  logic [1:0]                  i_Parity,
  input  logic                        i_Stop2,
  input  logic                        i_Wr,
  input  logic [DATA_WIDTH-1:0]       i_Data,
  output logic                        o_Tx_Serial,
  output logic                        o_Pready,
  output logic                        o_Busy,
  output logic                        o_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_Count,
  output logic                        o_Overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int BIW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         C_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [BIW-1:0]        C_LAST_BIT = BIW'(DATA_WIDTH - 1);
  localparam logic [BAUD_WIDTH-1:0] C_MIN_BAUD = BAUD_WIDTH'(2);
  localparam logic [BAUD_WIDTH-1:0] C_ONE      = BAUD_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [BAUD_WIDTH-1:0]   tb_q, tb_d;
  logic [BAUD_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BIW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    stop2_q, stop2_d;
  logic                    second_q, second_d;
  logic                    tx_q, tx_d;
  logic                    done_q, done_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic                    full, push, pop, launch, can_start, bit_end;
  logic [BAUD_WIDTH-1:0]   tb_last, cnt_inc, baud_eff;
  logic [DATA_WIDTH-1:0]   head;

  // Push/pop decisions use the pre-edge occupancy, so a full FIFO drops a write
  // even when a word leaves on the same edge.
  always_comb begin
    full      = (count_q == C_DEPTH);
    push      = i_Wr && !full;
    head      = mem_q[rd_ptr_q];
    can_start = (count_q != '0) && i_Enable;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
    ovf_d     = ovf_q | (i_Wr & full);
    baud_eff  = (i_Baud < C_MIN_BAUD) ? C_MIN_BAUD : i_Baud;
    tb_last   = tb_q - C_ONE;
    cnt_inc   = cnt_q + C_ONE;
    bit_end   = (cnt_q == tb_last);
  end

  always_comb begin
    state_d   = state_q;
    tb_d      = tb_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    second_d  = second_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    launch    = 1'b0;
    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        launch = can_start;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = data_q[0];
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == C_LAST_BIT) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d  = S_STOP;
              tx_d     = 1'b1;
              second_d = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIW'(1);
            data_d    = data_q >> 1;
            tx_d      = data_q[1];
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d  = S_STOP;
          cnt_d    = '0;
          tx_d     = 1'b1;
          second_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (stop2_q && !second_q) begin
            second_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            launch  = can_start;
          end
        end else begin
          // Done is registered so it is high during the final stop cycle.
          cnt_d  = cnt_inc;
          done_d = (cnt_inc == tb_last) && (!stop2_q || second_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      pop       = 1'b1;
      state_d   = S_START;
      tb_d      = baud_eff;
      cnt_d     = '0;
      bit_idx_d = '0;
      data_d    = head;
      par_en_d  = ^i_Parity;
      par_bit_d = (^head) ^ i_Parity[0];
      stop2_d   = i_Stop2;
      second_d  = 1'b0;
      tx_d      = 1'b0;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      tb_q      <= C_MIN_BAUD;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      second_q  <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tb_q      <= tb_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      second_q  <= second_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (push && !i_Reset) begin
      mem_q[wr_ptr_q] <= i_Data;
    end
  end

  assign o_Tx_Serial = tx_q;
  assign o_Pready    = !full;
  assign o_Busy      = (state_q != S_IDLE);
  assign o_Done      = done_q;
  assign o_Count     = count_q;
  assign o_Overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_txshift_fifo.sv
`default_nettype none
// tb_txshift_fifo : directed scenarios plus randomized traffic against a
// frame-level reference model of the transmitter.
module tb_txshift_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int BW    = 14;

  logic          clk = 1'b0;
  logic          rst, en, stop2, wr;
  logic [1:0]    par;
  logic [BW-1:0] baud;
  logic [DW-1:0] data;
  logic          tx, pready, busy, done, ovf;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of words, and the current frame as a list of bits.
  int mq[$];
  bit mbits[$];
  bit m_busy = 1'b0;
  bit m_ovf  = 1'b0;
  int m_t    = 0;
  int m_tb   = 2;
  int m_len  = 0;

  always #5 clk = ~clk;

  txshift_fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BAUD_WIDTH(BW)) dut (
    .i_Pclk(clk), .i_Reset(rst), .i_Baud(baud), .i_Enable(en),
    .i_Parity(par), .i_Stop2(stop2), .i_Wr(wr), .i_Data(data),
    .o_Tx_Serial(tx), .o_Pready(pready), .o_Busy(busy), .o_Done(done),
    .o_Count(count), .o_Overflow(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_start(input int d);
    logic [DW-1:0] v;
    v = d[DW-1:0];
    mbits.delete();
    mbits.push_back(1'b0);
    for (int i = 0; i < DW; i++) mbits.push_back(v[i]);
    if (par == 2'b01) mbits.push_back(~^v);
    else if (par == 2'b10) mbits.push_back(^v);
    mbits.push_back(1'b1);
    if (stop2) mbits.push_back(1'b1);
    m_tb   = (baud < 2) ? 2 : int'(baud);
    m_len  = m_tb * mbits.size();
    m_t    = 0;
    m_busy = 1'b1;
  endtask

  task automatic model_edge();
    int n;
    bit ends, popw;
    n = mq.size();
    if (rst) begin
      mq.delete();
      m_busy = 1'b0;
      m_ovf  = 1'b0;
      m_t    = 0;
    end else begin
      ends = m_busy && (m_t == m_len - 1);
      popw = (!m_busy || ends) && (n > 0) && en;
      if (m_busy) m_t++;
      if (ends) m_busy = 1'b0;
      if (popw) model_start(mq.pop_front());
      if (wr) begin
        if (n < DEPTH) mq.push_back(int'(data));
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("tx", tx, m_busy ? mbits[m_t / m_tb] : 1'b1);
    check("busy", busy, m_busy);
    check("done", done, m_busy && (m_t == m_len - 1));
    check("count", count, mq.size());
    check("pready", pready, mq.size() < DEPTH);
    check("overflow", ovf, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] p, input logic s2,
                           input logic [BW-1:0] b, output int len, output logic pbit);
    par = p; stop2 = s2; baud = b; en = 1'b1;
    wr = 1'b1; data = d;
    step();
    wr = 1'b0;
    len  = -1;
    pbit = 1'bx;
    for (int i = 1; i <= 200 && len < 0; i++) begin
      step();
      if (i == 37) pbit = tx;
      if (done) len = i;
    end
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int len, ndone, gap, nlow;
    logic pb;
    logic [9:0] exp038;
    rst = 1'b1; en = 1'b1; stop2 = 1'b0; wr = 1'b0; par = 2'b00;
    baud = 14'd4; data = '0;
    step();
    step();
    rst = 1'b0;

    // 0x53, no parity, one stop bit, 4 clocks per bit
    exp038 = 10'b1010100110;
    wr = 1'b1; data = 8'h53;
    step();
    wr = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      step();
      check("s038_line", tx, exp038[(i - 1) / 4]);
    end
    check("s038_done_k40", done, 1);
    step();
    check("s038_idle", busy, 0);

    run_frame(8'h53, 2'b10, 1'b1, 14'd4, len, pb);
    check("even_stop2_len", len, 48);
    check("even_parity_bit", pb, 0);
    run_frame(8'h53, 2'b01, 1'b0, 14'd4, len, pb);
    check("odd_len", len, 44);
    check("odd_parity_bit", pb, 1);
    run_frame(8'h53, 2'b00, 1'b0, 14'd1, len, pb);
    check("baud1_len", len, 20);

    // six back-to-back writes while idle
    do_reset();
    baud = 14'd2; par = 2'b00; stop2 = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; data = 8'(16 + i);
      step();
    end
    wr = 1'b0;
    check("s040_overflow", ovf, 1);
    check("s040_pready", pready, 0);
    check("s040_count", count, 4);
    ndone = 0; gap = 0;
    for (int i = 0; i < 300 && ndone < 5; i++) begin
      step();
      if (done) ndone++;
      else if (!busy) gap++;
    end
    check("s040_frames", ndone, 5);
    check("s040_gap", gap, 0);
    step();
    check("s040_drained", busy, 0);

    // enable drops mid-frame with a word queued
    do_reset();
    baud = 14'd2; en = 1'b1;
    wr = 1'b1; data = 8'hA5; step();
    data = 8'h3C; step();
    wr = 1'b0;
    for (int i = 0; i < 9; i++) step();
    en = 1'b0;
    ndone = 0;
    for (int i = 0; i < 100 && ndone == 0; i++) begin
      step();
      if (done) ndone++;
    end
    check("s041_done", ndone, 1);
    for (int i = 0; i < 6; i++) step();
    check("s041_line_high", tx, 1);
    check("s041_idle", busy, 0);
    check("s041_retained", count, 1);
    en = 1'b1;
    step();
    check("s041_restart_line", tx, 0);
    check("s041_restart_busy", busy, 1);
    for (int i = 0; i < 100 && busy; i++) step();

    // reset mid-frame with two words queued
    do_reset();
    baud = 14'd2;
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; data = 8'(8'hC0 + i);
      step();
    end
    wr = 1'b0;
    for (int i = 0; i < 13; i++) step();
    rst = 1'b1;
    step();
    check("s042_line", tx, 1);
    check("s042_count", count, 0);
    check("s042_done", done, 0);
    rst = 1'b0;
    ndone = 0; nlow = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (done) ndone++;
      if (!tx) nlow++;
    end
    check("s042_no_done", ndone, 0);
    check("s042_no_frames", nlow, 0);

    // reset beats a simultaneous write
    rst = 1'b1; wr = 1'b1; data = 8'h77;
    step();
    check("s037_count", count, 0);
    check("s037_overflow", ovf, 0);
    rst = 1'b0; wr = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst   = ($urandom_range(0, 599) == 0);
      wr    = ($urandom_range(0, 3) == 0);
      data  = 8'($urandom);
      par   = 2'($urandom);
      stop2 = 1'($urandom);
      baud  = 14'($urandom_range(0, 4));
      en    = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
